// File: rtl/bar_overlay.sv
// bar_overlay: per-pixel bar-graph hit test with frame-synchronous level shadows and a 2-stage priority pipeline.
// Optional outline drawing is compiled in with `define OUTLINE_MODE_EN.
module bar_overlay #(
   parameter int CH = 2,
   parameter int XW = 11,
   parameter int YW = 10,
   parameter logic [CH*XW-1:0] ORG_X = {11'd171, 11'd11},
   parameter logic [CH*YW-1:0] ORG_Y = {10'd11, 10'd11}
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           en,
   input  logic           vs,
   input  logic           px_valid,
   input  logic [XW-1:0]  gr_x,
   input  logic [YW-1:0]  gr_y,
   input  logic [CH*XW-1:0] lvl_x,
   input  logic [CH*YW-1:0] lvl_y,
   input  logic           outline,
   output logic           out_valid,
   output logic           outg,
   output logic [1:0]     out_ch
);
   logic [XW-1:0] sh_x [CH];
   logic [YW-1:0] sh_y [CH];
   logic          sh_ol;
   logic [CH-1:0] hit, hit_q;
   logic          v1;
   logic [1:0]    win;

   // outline mode flag is latched together with the levels at frame start
   always_ff @(posedge clk or negedge reset)
      if (!reset) sh_ol <= 1'b0;
      else if (vs && en) sh_ol <= outline;

   for (genvar k = 0; k < CH; k++) begin : g_ch
      localparam logic [XW-1:0] OX = ORG_X[k*XW +: XW];
      localparam logic [YW-1:0] OY = ORG_Y[k*YW +: YW];
      localparam logic [XW-1:0] OXM1 = OX - XW'(1);
      logic fill;
      // shadow levels: reset to an empty bar, reload only at an enabled frame start
      always_ff @(posedge clk or negedge reset)
         if (!reset) begin
            sh_x[k] <= OXM1;
            sh_y[k] <= OY;
         end else if (vs && en) begin
            sh_x[k] <= lvl_x[k*XW +: XW];
            sh_y[k] <= lvl_y[k*YW +: YW];
         end
      // an inverted rectangle (level below origin) can never satisfy both bounds, so it is empty
      assign fill = gr_x >= OX && gr_x <= sh_x[k] && gr_y >= OY && gr_y <= sh_y[k];
`ifdef OUTLINE_MODE_EN
      assign hit[k] = fill && (!sh_ol || gr_x == OX || gr_x == sh_x[k] || gr_y == OY || gr_y == sh_y[k]);
`else
      assign hit[k] = fill;
`endif
   end

`ifndef OUTLINE_MODE_EN
   logic unused_ol;
   assign unused_ol = sh_ol;
`endif

   // stage 1: capture qualified hit vector; disabled or invalid pixels carry no hits
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         v1    <= 1'b0;
         hit_q <= '0;
      end else begin
         v1    <= px_valid;
         hit_q <= (px_valid && en) ? hit : '0;
      end

   // lowest-index hit wins
   always_comb begin
      win = 2'd0;
      for (int i = CH - 1; i >= 0; i--) if (hit_q[i]) win = 2'(i);
   end

   // stage 2: registered priority result
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         out_valid <= 1'b0;
         outg      <= 1'b0;
         out_ch    <= 2'd0;
      end else begin
         out_valid <= v1;
         outg      <= v1 && |hit_q;
         out_ch    <= v1 ? win : 2'd0;
      end
endmodule

// File: tb/tb_bar_overlay.sv
// tb_bar_overlay: directed vector table plus hand sequences for same-cycle vs, streaming and mid-frame reset.
module tb_bar_overlay;
   localparam int CH = 2;
   localparam int XW = 11;
   localparam int YW = 10;
`ifdef OUTLINE_MODE_EN
   localparam bit OL = 1'b1;
`else
   localparam bit OL = 1'b0;
`endif

   logic clk = 1'b0, reset = 1'b0, en = 1'b0, vs = 1'b0, px_valid = 1'b0, outline = 1'b0;
   logic [XW-1:0] gr_x = '0;
   logic [YW-1:0] gr_y = '0;
   logic [CH*XW-1:0] lvl_x = '0;
   logic [CH*YW-1:0] lvl_y = '0;
   logic out_valid, outg;
   logic [1:0] out_ch;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   bar_overlay #(.CH(CH), .XW(XW), .YW(YW), .ORG_X({11'd11, 11'd11}), .ORG_Y({10'd11, 10'd11})) dut (
      .clk(clk), .reset(reset), .en(en), .vs(vs), .px_valid(px_valid),
      .gr_x(gr_x), .gr_y(gr_y), .lvl_x(lvl_x), .lvl_y(lvl_y), .outline(outline),
      .out_valid(out_valid), .outg(outg), .out_ch(out_ch)
   );

   typedef struct {
      bit ld; bit e; bit ol;
      int lx0; int ly0; int lx1; int ly1;
      int gx; int gy;
      bit g; int ch;
   } vec_t;
   vec_t tv[19];

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: {valid,g,ch} got %b want %b", nm, act, exp);
      end
   endtask

   int sx[4] = '{15, 25, 20, 21};
   int sy[4] = '{15, 15, 60, 60};
   bit sg[4] = '{1, 0, 1, 0};

   initial begin
      tv[0]  = '{0, 1, 0,   0,   0,   0,   0,  11, 11, 0, 0};
      tv[1]  = '{1, 1, 0,  50,  60,   5,   5,  30, 30, 1, 0};
      tv[2]  = '{0, 1, 0,   0,   0,   0,   0,  51, 30, 0, 0};
      tv[3]  = '{0, 1, 0,   0,   0,   0,   0,  50, 60, 1, 0};
      tv[4]  = '{0, 1, 0,   0,   0,   0,   0,  11, 11, 1, 0};
      tv[5]  = '{0, 1, 0,   0,   0,   0,   0,  10, 30, 0, 0};
      tv[6]  = '{0, 1, 0,   0,   0,   0,   0,  30, 61, 0, 0};
      tv[7]  = '{1, 1, 0, 100, 100, 100, 100,  30, 30, 1, 0};
      tv[8]  = '{1, 1, 0,  20, 100, 100, 100,  50, 30, 1, 1};
      tv[9]  = '{1, 1, 0,   5,  60,   5,   5,  11, 11, 0, 0};
      tv[10] = '{0, 1, 0,   0,   0,   0,   0,   5, 30, 0, 0};
      tv[11] = '{0, 1, 0,   0,   0,   0,   0,  30, 30, 0, 0};
      tv[12] = '{1, 0, 0,  50,  60,   5,   5,  30, 30, 0, 0};
      tv[13] = '{0, 1, 0,   0,   0,   0,   0,  30, 30, 1, 0};
      tv[14] = '{1, 1, 1,  50,  60,   5,   5,  30, 30, !OL, 0};
      tv[15] = '{0, 1, 0,   0,   0,   0,   0,  11, 30, 1, 0};
      tv[16] = '{0, 1, 0,   0,   0,   0,   0,  30, 60, 1, 0};
      tv[17] = '{0, 1, 0,   0,   0,   0,   0,  50, 45, 1, 0};
      tv[18] = '{1, 1, 0,  50,  60,   5,   5,  30, 30, 1, 0};

      repeat (2) @(negedge clk);
      chk("reset", {out_valid, outg, out_ch}, 4'b0000);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 19; i++) begin
         if (tv[i].ld) begin
            vs = 1'b1; en = 1'b1; outline = tv[i].ol;
            lvl_x = {XW'(tv[i].lx1), XW'(tv[i].lx0)};
            lvl_y = {YW'(tv[i].ly1), YW'(tv[i].ly0)};
            @(negedge clk);
            vs = 1'b0;
         end
         en = tv[i].e; gr_x = XW'(tv[i].gx); gr_y = YW'(tv[i].gy); px_valid = 1'b1;
         @(negedge clk);
         px_valid = 1'b0;
         chk($sformatf("v%0d_latency", i), {out_valid, outg, out_ch}, 4'b0000);
         @(negedge clk);
         chk($sformatf("v%0d", i), {out_valid, outg, out_ch}, {1'b1, tv[i].g, 2'(tv[i].ch)});
         en = 1'b1;
      end

      // vs and pixel together: old shadow (50,60) applies, new level 20 applies next cycle
      vs = 1'b1; en = 1'b1; outline = 1'b0;
      lvl_x = {11'd5, 11'd20}; lvl_y = {10'd5, 10'd60};
      gr_x = 11'd40; gr_y = 10'd30; px_valid = 1'b1;
      @(negedge clk);
      vs = 1'b0;
      @(negedge clk);
      px_valid = 1'b0;
      chk("same_cycle_old", {out_valid, outg, out_ch}, 4'b1100);
      @(negedge clk);
      chk("next_cycle_new", {out_valid, outg, out_ch}, 4'b1000);
      @(negedge clk);
      chk("drain", {out_valid, outg, out_ch}, 4'b0000);

      // back-to-back pixels against shadow (20,60): one output per input, no bubbles
      for (int i = 0; i < 6; i++) begin
         if (i < 4) begin
            px_valid = 1'b1; gr_x = XW'(sx[i]); gr_y = YW'(sy[i]);
         end else px_valid = 1'b0;
         if (i >= 2) chk($sformatf("stream%0d", i - 2), {out_valid, outg, out_ch}, {1'b1, sg[i - 2], 2'b00});
         @(negedge clk);
      end
      chk("stream_end", {out_valid, outg, out_ch}, 4'b0000);

      // mid-frame asynchronous reset discards in-flight pixels and empties the bars
      gr_x = 11'd15; gr_y = 10'd15; px_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset", {out_valid, outg, out_ch}, 4'b1100);
      #2 reset = 1'b0; px_valid = 1'b0;
      #1 chk("async_clear", {out_valid, outg, out_ch}, 4'b0000);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("post_reset_idle", {out_valid, outg, out_ch}, 4'b0000);
      px_valid = 1'b1;
      @(negedge clk);
      px_valid = 1'b0;
      chk("post_reset_latency", {out_valid, outg, out_ch}, 4'b0000);
      @(negedge clk);
      chk("post_reset_empty", {out_valid, outg, out_ch}, 4'b1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
